// File: rtl/override_sched.sv
// Override-request pulse generator for the interface y bit.
// Each started burst issues windows of (hold+1) high cycles, each preceded by
// (period+1) low cycles. Configuration is captured at start; i_en low aborts.
module override_sched #(
    parameter int unsigned PER_W   = 3,
    parameter int unsigned HOLD_W  = 2,
    parameter int unsigned BURST_W = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_start,
    input  logic [PER_W-1:0]   i_period,
    input  logic [HOLD_W-1:0]  i_hold,
    input  logic [BURST_W-1:0] i_burst,
    output logic               o_y,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_ovr_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAssert
    } state_e;

    state_e             state_q, state_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [PER_W-1:0]   wcnt_q, wcnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [HOLD_W-1:0]  hcnt_q, hcnt_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] issued_q, issued_d;
    logic [BURST_W-1:0] issued_inc;
    logic [CNT_W-1:0]   ovr_cnt_q, ovr_cnt_d;
    logic               y_q, y_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Wraps silently in free-run; only compared when a burst length is set.
    assign issued_inc = issued_q + BURST_W'(1);

    // Next-state and registered-output logic; i_en low outranks every other transition.
    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        wcnt_d    = wcnt_q;
        hold_d    = hold_q;
        hcnt_d    = hcnt_q;
        burst_d   = burst_q;
        issued_d  = issued_q;
        ovr_cnt_d = ovr_cnt_q;
        y_d       = y_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_start && i_en) begin
                    per_d    = i_period;
                    hold_d   = i_hold;
                    burst_d  = i_burst;
                    issued_d = '0;
                    wcnt_d   = i_period;
                    state_d  = StWait;
                    busy_d   = 1'b1;
                end
            end
            StWait: begin
                if (!i_en) begin
                    state_d = StIdle;
                    y_d     = 1'b0;
                    busy_d  = 1'b0;
                end else if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - PER_W'(1);
                end else begin
                    state_d = StAssert;
                    y_d     = 1'b1;
                    hcnt_d  = hold_q;
                end
            end
            StAssert: begin
                if (!i_en) begin
                    // Truncated window: not counted, no completion pulse.
                    state_d = StIdle;
                    y_d     = 1'b0;
                    busy_d  = 1'b0;
                end else if (hcnt_q != '0) begin
                    hcnt_d = hcnt_q - HOLD_W'(1);
                end else begin
                    y_d      = 1'b0;
                    issued_d = issued_inc;
                    if (ovr_cnt_q != {CNT_W{1'b1}}) begin
                        ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
                    end
                    if ((burst_q != '0) && (issued_inc == burst_q)) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StWait;
                        wcnt_d  = per_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                y_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            per_q     <= '0;
            wcnt_q    <= '0;
            hold_q    <= '0;
            hcnt_q    <= '0;
            burst_q   <= '0;
            issued_q  <= '0;
            ovr_cnt_q <= '0;
            y_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            wcnt_q    <= wcnt_d;
            hold_q    <= hold_d;
            hcnt_q    <= hcnt_d;
            burst_q   <= burst_d;
            issued_q  <= issued_d;
            ovr_cnt_q <= ovr_cnt_d;
            y_q       <= y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_y       = y_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_ovr_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_override_sched.sv
// Bench for override_sched: a time-since-start model predicts every output each
// cycle; directed scenarios add literal expectations at hand-computed cycles.
module tb_override_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       start;
    logic [2:0] period;
    logic [1:0] hold;
    logic [3:0] burst;

    logic       y, busy, done;
    logic [7:0] cnt8;
    logic       y2, busy2, done2;
    logic [1:0] cnt2;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: a burst is a run of identical windows of length L=P+H+2 counted from
    // the start edge (t=0); y is high for offsets P+1..L-1 of each window.
    int m_active = 0;
    int m_t      = 0;
    int m_done   = 0;
    int m_total  = 0;
    int m_p      = 0;
    int m_h      = 0;
    int m_b      = 0;

    always #5 clk = ~clk;

    override_sched #(.PER_W(3), .HOLD_W(2), .BURST_W(4), .CNT_W(8)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_start   (start),
        .i_period  (period),
        .i_hold    (hold),
        .i_burst   (burst),
        .o_y       (y),
        .o_busy    (busy),
        .o_done    (done),
        .o_ovr_cnt (cnt8)
    );

    override_sched #(.PER_W(3), .HOLD_W(2), .BURST_W(4), .CNT_W(2)) dut_w2 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_start   (start),
        .i_period  (period),
        .i_hold    (hold),
        .i_burst   (burst),
        .o_y       (y2),
        .o_busy    (busy2),
        .o_done    (done2),
        .o_ovr_cnt (cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int exp_y();
        int len;
        if (m_active == 0) return 0;
        len = m_p + m_h + 2;
        return ((m_t % len) > m_p) ? 1 : 0;
    endfunction

    // Model update on each active edge or asynchronous reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (rst_n !== 1'b1) begin
                m_active = 0;
                m_t      = 0;
                m_done   = 0;
                m_total  = 0;
            end else if (m_active != 0) begin
                m_done = 0;
                if (!en) begin
                    m_active = 0;
                end else begin
                    m_t++;
                    if ((m_t % (m_p + m_h + 2)) == 0) begin
                        m_total++;
                        if (m_b != 0 && m_t == m_b * (m_p + m_h + 2)) begin
                            m_active = 0;
                            m_done   = 1;
                        end
                    end
                end
            end else begin
                m_done = 0;
                if (start && en) begin
                    m_active = 1;
                    m_t      = 0;
                    m_p      = int'(period);
                    m_h      = int'(hold);
                    m_b      = int'(burst);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_y",      {31'd0, y},     exp_y());
            check("cmp_busy",   {31'd0, busy},  m_active);
            check("cmp_done",   {31'd0, done},  m_done);
            check("cmp_cnt8",   {24'd0, cnt8},  sat(m_total, 8));
            check("cmp_y_w2",   {31'd0, y2},    exp_y());
            check("cmp_cnt2",   {30'd0, cnt2},  sat(m_total, 2));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_y"},    {31'd0, y},    0);
        check({name, "_busy"}, {31'd0, busy}, 0);
        check({name, "_done"}, {31'd0, done}, 0);
        check({name, "_cnt8"}, {24'd0, cnt8}, 0);
        check({name, "_cnt2"}, {30'd0, cnt2}, 0);
    endtask

    initial begin
        rst_n  = 1'b1;
        en     = 1'b0;
        start  = 1'b0;
        period = '0;
        hold   = '0;
        burst  = '0;
        #1 rst_n = 1'b0;
        tick();
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // P=4 H=0 B=3: y high in cycles 5, 11, 17; done in 18.
        en = 1'b1; start = 1'b1; period = 3'd4; hold = 2'd0; burst = 4'd3;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 0) start = 1'b0;
            check("t1_y",    {31'd0, y},    (c == 5 || c == 11 || c == 17) ? 1 : 0);
            check("t1_done", {31'd0, done}, (c == 18) ? 1 : 0);
            check("t1_busy", {31'd0, busy}, (c < 18) ? 1 : 0);
            if (c == 18) check("t1_cnt", {24'd0, cnt8}, 3);
        end

        // P=0 H=3 B=1: y high cycles 1-4, done at 5; mid-burst config changes ignored.
        start = 1'b1; period = 3'd0; hold = 2'd3; burst = 4'd1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 0) start = 1'b0;
            if (c == 2) begin period = 3'd7; hold = 2'd0; burst = 4'd5; end
            check("t2_y",    {31'd0, y},    (c >= 1 && c <= 4) ? 1 : 0);
            check("t2_done", {31'd0, done}, (c == 5) ? 1 : 0);
            if (c == 6) check("t2_cnt", {24'd0, cnt8}, 4);
        end

        // P=2 H=1 B=2 with a start pulse while busy, then restart in the done cycle.
        start = 1'b1; period = 3'd2; hold = 2'd1; burst = 4'd2;
        for (int c = 0; c < 17; c++) begin
            tick();
            if (c == 0) start = 1'b0;
            if (c == 3) start = 1'b1;
            if (c == 4) start = 1'b0;
            check("t4_y", {31'd0, y},
                  (c == 3 || c == 4 || c == 8 || c == 9 || c == 13) ? 1 : 0);
            check("t4_done", {31'd0, done}, (c == 10 || c == 14) ? 1 : 0);
            check("t4_busy", {31'd0, busy}, ((c < 10) || (c >= 11 && c < 14)) ? 1 : 0);
            if (c == 10) begin start = 1'b1; period = 3'd1; hold = 2'd0; burst = 4'd1; end
            if (c == 11) start = 1'b0;
            if (c == 15) check("t4_cnt", {24'd0, cnt8}, 7);
        end

        // Asynchronous reset mid-WAIT.
        start = 1'b1; period = 3'd3; hold = 2'd2; burst = 4'd0;
        tick(); start = 1'b0;
        tick();
        tick();
        check("t5_busy_pre", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t5_wait_rst");
        tick();
        rst_n = 1'b1;

        // Asynchronous reset mid-ASSERT.
        start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) start = 1'b0;
        end
        check("t5_y_pre", {31'd0, y}, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t5_asrt_rst");
        tick();
        rst_n = 1'b1;

        // Free-run P=1 H=1 after restart: 2-high/2-low; narrow counter saturates.
        start = 1'b1; period = 3'd1; hold = 2'd1; burst = 4'd0;
        for (int c = 0; c < 23; c++) begin
            tick();
            if (c == 0) start = 1'b0;
            check("t3_y", {31'd0, y}, ((c % 4) >= 2) ? 1 : 0);
            if (c == 21) begin
                check("t3_cnt8", {24'd0, cnt8}, 5);
                check("t3_cnt2", {30'd0, cnt2}, 3);
            end
        end
        // Cycle 22 is mid-ASSERT: abort.
        en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t3_abort_y",    {31'd0, y},    0);
            check("t3_abort_busy", {31'd0, busy}, 0);
            check("t3_abort_done", {31'd0, done}, 0);
            check("t3_abort_cnt",  {24'd0, cnt8}, 5);
        end

        // Start with i_en low in IDLE is ignored.
        start = 1'b1;
        tick();
        tick();
        check("t6_busy", {31'd0, busy}, 0);
        start = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
